// File: rtl/fifo_rd_formatter.sv
// fifo_rd_formatter: downlink reader for one channel FIFO. Waits until a full
// packet is stored, requests the output arbiter and, once granted, drains the
// packet as a framed stream with start/end markers and channel sideband.
module fifo_rd_formatter #(
    parameter int FIFO_DEPTH    = 8,
    parameter int FIFO_WIDE     = 32,
    parameter int FIFO_PTR_WIDE = 3,
    parameter int CH_ID_WIDE    = 2,
    parameter int CH_ID         = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fmt_en,
    input  logic [FIFO_PTR_WIDE:0]   pkt_len,
    input  logic [FIFO_PTR_WIDE:0]   fifo_slack,
    input  logic                     fifo_empty,
    input  logic [FIFO_WIDE-1:0]     fifo_data,
    output logic                     fifo_rd_en,
    output logic                     fmt_req,
    input  logic                     fmt_grant,
    output logic                     fmt_valid,
    output logic [FIFO_WIDE-1:0]     fmt_data,
    output logic                     fmt_start,
    output logic                     fmt_end,
    output logic [CH_ID_WIDE-1:0]    fmt_chid,
    output logic [FIFO_PTR_WIDE:0]   fmt_length,
    output logic                     underflow_err
);

    localparam int            CW      = FIFO_PTR_WIDE + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    typedef enum logic [1:0] {IDLE, REQ, SEND, FLUSH} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] occ;
    logic [CW-1:0] eff_len;
    logic [CW-1:0] len_q;
    logic [CW-1:0] rd_cnt;
    logic [CW-1:0] out_idx;
    logic          start_pkt;
    logic          rd_fire;
    logic          last_rd;

    assign occ = DEPTH_C - fifo_slack;

    // Effective packet length: 0 means one word, oversize clamps to the FIFO depth
    always_comb begin
        eff_len = pkt_len;
        if (pkt_len == '0) begin
            eff_len = ONE_C;
        end else if (pkt_len > DEPTH_C) begin
            eff_len = DEPTH_C;
        end
    end

    assign start_pkt = (state == IDLE) && fmt_en && (occ >= eff_len);
    assign rd_fire   = (state == SEND) && !fifo_empty;
    assign last_rd   = rd_fire && (rd_cnt == len_q - ONE_C);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; an empty FIFO in SEND only stalls, it never aborts
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_pkt) state_nxt = REQ;
            REQ:     if (fmt_grant) state_nxt = SEND;
            SEND:    if (last_rd)   state_nxt = FLUSH;
            FLUSH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        fmt_req    = 1'b0;
        fifo_rd_en = 1'b0;
        case (state)
            REQ:     fmt_req    = 1'b1;
            SEND:    fifo_rd_en = !fifo_empty;
            default: ;
        endcase
    end

    // Length latch, read counter, presented-word index, valid and sticky underflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q         <= '0;
            rd_cnt        <= '0;
            out_idx       <= '0;
            fmt_valid     <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            fmt_valid <= rd_fire;
            if (start_pkt) begin
                len_q  <= eff_len;
                rd_cnt <= '0;
            end
            if (rd_fire) begin
                out_idx <= rd_cnt;
                rd_cnt  <= rd_cnt + ONE_C;
            end
            if ((state == SEND) && fifo_empty) begin
                underflow_err <= 1'b1;
            end
        end
    end

    assign fmt_start  = fmt_valid && (out_idx == '0);
    assign fmt_end    = fmt_valid && (out_idx == len_q - ONE_C);
    assign fmt_length = len_q;
    assign fmt_chid   = CH_ID_WIDE'(CH_ID);
    assign fmt_data   = fifo_data;

endmodule

// File: tb/tb_fifo_rd_formatter.sv
// Directed bench for fifo_rd_formatter with a small behavioural FIFO model.
module tb_fifo_rd_formatter;

    logic        clk = 1'b0;
    logic        rst;
    logic        fmt_en;
    logic [3:0]  pkt_len;
    logic [3:0]  fifo_slack;
    logic        fifo_empty;
    logic [31:0] fifo_data = '0;
    logic        fifo_rd_en;
    logic        fmt_req;
    logic        fmt_grant;
    logic        fmt_valid;
    logic [31:0] fmt_data;
    logic        fmt_start;
    logic        fmt_end;
    logic [1:0]  fmt_chid;
    logic [3:0]  fmt_length;
    logic        underflow_err;

    // FIFO model state
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic        force_empty = 1'b0;
    logic [31:0] mem [8];
    logic [2:0]  wp = '0;
    logic [2:0]  rp = '0;
    logic [3:0]  cnt_m = '0;

    int n_cmp = 0;
    int n_err = 0;

    fifo_rd_formatter #(
        .FIFO_DEPTH   (8),
        .FIFO_WIDE    (32),
        .FIFO_PTR_WIDE(3),
        .CH_ID_WIDE   (2),
        .CH_ID        (0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fmt_en       (fmt_en),
        .pkt_len      (pkt_len),
        .fifo_slack   (fifo_slack),
        .fifo_empty   (fifo_empty),
        .fifo_data    (fifo_data),
        .fifo_rd_en   (fifo_rd_en),
        .fmt_req      (fmt_req),
        .fmt_grant    (fmt_grant),
        .fmt_valid    (fmt_valid),
        .fmt_data     (fmt_data),
        .fmt_start    (fmt_start),
        .fmt_end      (fmt_end),
        .fmt_chid     (fmt_chid),
        .fmt_length   (fmt_length),
        .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    // FIFO: read data appears the cycle after the read strobe
    always @(posedge clk) begin
        if (wr_en) begin
            mem[wp] <= wr_data;
            wp      <= wp + 3'd1;
        end
        if (fifo_rd_en) begin
            fifo_data <= mem[rp];
            rp        <= rp + 3'd1;
        end
        cnt_m <= cnt_m + (wr_en ? 4'd1 : 4'd0) - (fifo_rd_en ? 4'd1 : 4'd0);
    end

    assign fifo_slack = 4'd8 - cnt_m;
    assign fifo_empty = force_empty | (cnt_m == 4'd0);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick;
        wr_en   = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (fmt_req) break;
            tick;
        end
        chk({tag, "_req"}, 64'(fmt_req), 64'd1);
    endtask

    // Grant from REQ and check the whole read/present window cycle by cycle
    task automatic drain(input int len, input logic [31:0] base, input string tag);
        fmt_grant = 1'b1;
        tick;
        fmt_grant = 1'b0;
        for (int i = 0; i <= len; i++) begin
            chk({tag, "_rd"},    64'(fifo_rd_en), 64'(i < len));
            chk({tag, "_valid"}, 64'(fmt_valid),  64'(i >= 1));
            chk({tag, "_len"},   64'(fmt_length), 64'(len));
            if (i >= 1) begin
                chk({tag, "_data"},  64'(fmt_data),  64'(base + 32'(i - 1)));
                chk({tag, "_start"}, 64'(fmt_start), 64'(i == 1));
                chk({tag, "_end"},   64'(fmt_end),   64'(i == len));
                chk({tag, "_chid"},  64'(fmt_chid),  64'd0);
            end
            tick;
        end
    endtask

    initial begin
        rst       = 1'b1;
        fmt_en    = 1'b0;
        pkt_len   = 4'd0;
        fmt_grant = 1'b0;
        tick;
        tick;
        chk("rst_req",    64'(fmt_req),       64'd0);
        chk("rst_rd",     64'(fifo_rd_en),    64'd0);
        chk("rst_valid",  64'(fmt_valid),     64'd0);
        chk("rst_start",  64'(fmt_start),     64'd0);
        chk("rst_end",    64'(fmt_end),       64'd0);
        chk("rst_len",    64'(fmt_length),    64'd0);
        chk("rst_uflow",  64'(underflow_err), 64'd0);
        chk("rst_chid",   64'(fmt_chid),      64'd0);
        rst = 1'b0;
        tick;

        // Length 4, grant three cycles after the request
        for (int i = 0; i < 4; i++) push(32'hA0 + 32'(i));
        pkt_len = 4'd4;
        fmt_en  = 1'b1;
        tick;
        chk("l4_req", 64'(fmt_req), 64'd1);
        chk("l4_length", 64'(fmt_length), 64'd4);
        tick;
        chk("l4_hold_rd", 64'(fifo_rd_en), 64'd0);
        tick;
        chk("l4_hold_req", 64'(fmt_req), 64'd1);
        drain(4, 32'hA0, "l4");
        fmt_en = 1'b0;
        chk("l4_after_req", 64'(fmt_req), 64'd0);

        // Threshold: 4 stored words do not satisfy a length of 5
        pkt_len = 4'd5;
        for (int i = 0; i < 4; i++) push(32'hB0 + 32'(i));
        fmt_en = 1'b1;
        tick;
        tick;
        chk("thr_noreq0", 64'(fmt_req), 64'd0);
        tick;
        chk("thr_noreq1", 64'(fmt_req), 64'd0);
        push(32'hB4);
        chk("thr_slack3_noreq", 64'(fmt_req), 64'd0);
        tick;
        chk("thr_req", 64'(fmt_req), 64'd1);
        drain(5, 32'hB0, "thr");
        fmt_en = 1'b0;

        // pkt_len = 0 acts as a single-word packet
        pkt_len = 4'd0;
        push(32'hC0);
        fmt_en = 1'b1;
        wait_req("len0");
        drain(1, 32'hC0, "len0");
        fmt_en = 1'b0;

        // pkt_len above depth clamps to 8
        pkt_len = 4'd12;
        for (int i = 0; i < 8; i++) push(32'hD0 + 32'(i));
        fmt_en = 1'b1;
        wait_req("len12");
        drain(8, 32'hD0, "len12");
        fmt_en = 1'b0;

        // Grant pulse in IDLE is ignored
        push(32'hE0);
        push(32'hE1);
        fmt_grant = 1'b1;
        tick;
        fmt_grant = 1'b0;
        chk("idle_grant_rd",  64'(fifo_rd_en), 64'd0);
        chk("idle_grant_req", 64'(fmt_req),    64'd0);
        tick;
        chk("idle_grant_rd2", 64'(fifo_rd_en), 64'd0);

        // Request held for 20 cycles without grant
        pkt_len = 4'd2;
        fmt_en  = 1'b1;
        wait_req("hold");
        for (int i = 0; i < 20; i++) begin
            chk("hold_req", 64'(fmt_req),    64'd1);
            chk("hold_rd",  64'(fifo_rd_en), 64'd0);
            tick;
        end
        drain(2, 32'hE0, "hold");
        fmt_en = 1'b0;

        // Back-to-back packets of 2: FLUSH, one IDLE cycle, then the next request
        for (int i = 0; i < 4; i++) push(32'hF0 + 32'(i));
        fmt_en = 1'b1;
        wait_req("b2b");
        drain(2, 32'hF0, "b2b_a");
        chk("b2b_idle_req", 64'(fmt_req), 64'd0);
        tick;
        chk("b2b_next_req", 64'(fmt_req), 64'd1);
        drain(2, 32'hF2, "b2b_b");
        fmt_en = 1'b0;

        // Underflow: FIFO reports empty for two cycles mid-SEND
        pkt_len = 4'd4;
        for (int i = 0; i < 4; i++) push(32'h10 + 32'(i));
        fmt_en = 1'b1;
        wait_req("uf");
        fmt_en    = 1'b0;
        fmt_grant = 1'b1;
        tick;
        fmt_grant = 1'b0;
        chk("uf_rd0", 64'(fifo_rd_en), 64'd1);
        tick;
        chk("uf_rd1",    64'(fifo_rd_en), 64'd1);
        chk("uf_data0",  64'(fmt_data),   64'h10);
        chk("uf_start",  64'(fmt_start),  64'd1);
        tick;
        force_empty = 1'b1;
        #1;
        chk("uf_gap_rd0",   64'(fifo_rd_en),    64'd0);
        chk("uf_data1",     64'(fmt_data),      64'h11);
        chk("uf_flag_pre",  64'(underflow_err), 64'd0);
        tick;
        chk("uf_gap_rd1",   64'(fifo_rd_en),    64'd0);
        chk("uf_gap_valid", 64'(fmt_valid),     64'd0);
        chk("uf_flag",      64'(underflow_err), 64'd1);
        tick;
        force_empty = 1'b0;
        #1;
        chk("uf_rd2",      64'(fifo_rd_en), 64'd1);
        chk("uf_valid_lo", 64'(fmt_valid),  64'd0);
        tick;
        chk("uf_rd3",   64'(fifo_rd_en), 64'd1);
        chk("uf_data2", 64'(fmt_data),   64'h12);
        chk("uf_end_lo", 64'(fmt_end),   64'd0);
        tick;
        chk("uf_flush_rd", 64'(fifo_rd_en), 64'd0);
        chk("uf_data3",    64'(fmt_data),   64'h13);
        chk("uf_end",      64'(fmt_end),    64'd1);
        tick;
        chk("uf_done_valid", 64'(fmt_valid),     64'd0);
        chk("uf_sticky",     64'(underflow_err), 64'd1);

        // Reset after the second of six words
        pkt_len = 4'd6;
        for (int i = 0; i < 6; i++) push(32'h20 + 32'(i));
        fmt_en = 1'b1;
        wait_req("rm");
        fmt_en    = 1'b0;
        fmt_grant = 1'b1;
        tick;
        fmt_grant = 1'b0;
        tick;
        chk("rm_data0", 64'(fmt_data), 64'h20);
        tick;
        chk("rm_data1", 64'(fmt_data), 64'h21);
        rst = 1'b1;
        #1;
        chk("rm_rd",    64'(fifo_rd_en),    64'd0);
        chk("rm_valid", 64'(fmt_valid),     64'd0);
        chk("rm_start", 64'(fmt_start),     64'd0);
        chk("rm_end",   64'(fmt_end),       64'd0);
        chk("rm_req",   64'(fmt_req),       64'd0);
        chk("rm_len",   64'(fmt_length),    64'd0);
        chk("rm_uflow", 64'(underflow_err), 64'd0);
        chk("rm_chid",  64'(fmt_chid),      64'd0);
        tick;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("rm_noreq", 64'(fmt_req),    64'd0);
            chk("rm_nord",  64'(fifo_rd_en), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_rd_formatter.md
# fifo_rd_formatter

Downlink-side reader for one channel FIFO of the multi-channel data formatter. It watches the FIFO fill level, and once a full packet's worth of words is stored it requests the output arbiter. When granted, it drains exactly that many words with back-to-back FIFO reads and presents them downstream as a framed packet with start/end markers and channel sideband. It is the consumer counterpart of the uplink writer that drives the FIFO write side.

## Interface
- FIFO_DEPTH, 8, FIFO word capacity; must match the attached FIFO.
- FIFO_WIDE, 32, data word width.
- FIFO_PTR_WIDE, 3, FIFO pointer width; count/slack signals are FIFO_PTR_WIDE+1 bits.
- CH_ID_WIDE, 2, channel-ID width.
- CH_ID, 0, constant channel ID driven on fmt_chid.

- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- fmt_en  in  1  enables starting new packets.
- pkt_len  in  FIFO_PTR_WIDE+1  payload words per packet; 0 is treated as 1, values above FIFO_DEPTH are clamped to FIFO_DEPTH.
- fifo_slack  in  FIFO_PTR_WIDE+1  free FIFO entries.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  FIFO_WIDE  FIFO read data, valid the cycle after a read enable.
- fifo_rd_en  out  1  FIFO read strobe.
- fmt_req  out  1  arbitration request.
- fmt_grant  in  1  arbiter grant, single-cycle pulse.
- fmt_valid  out  1  fmt_data valid.
- fmt_data  out  FIFO_WIDE  packet word; equals fifo_data whenever fmt_valid is high.
- fmt_start  out  1  first word of packet.
- fmt_end  out  1  last word of packet.
- fmt_chid  out  CH_ID_WIDE  CH_ID, held for the whole packet.
- fmt_length  out  FIFO_PTR_WIDE+1  latched packet length, held from REQ through FLUSH.
- underflow_err  out  1  sticky; set if fifo_empty is seen while reading.

## Operation
- Occupancy: occ = FIFO_DEPTH - fifo_slack, computed at FIFO_PTR_WIDE+1 bits, unsigned.
- FSM states: IDLE, REQ, SEND, FLUSH.
- IDLE -> REQ:
  - Condition: fmt_en=1 and occ >= effective length.
  - Effective length (pkt_len after the 0/clamp rules) is latched into len_q and fmt_length.
  - Word counter is cleared to 0.
- REQ:
  - fmt_req=1.
  - fmt_en and pkt_len are ignored from here on.
  - On fmt_grant=1 -> SEND.
- SEND:
  - fifo_rd_en = !fifo_empty; the counter increments on each read.
  - Leaves for FLUSH on the cycle the read with counter = len_q-1 is issued.
- FLUSH: one cycle in which the last word is presented; then -> IDLE.
- fmt_valid = registered fifo_rd_en.
- fmt_start = fmt_valid and word index 0.
- fmt_end = fmt_valid and word index len_q-1.
- fmt_start and fmt_end are both high when len_q=1.
- fmt_grant outside REQ is ignored.
- Empty during SEND:
  - No read is issued; the counter holds.
  - underflow_err is set and held.
  - The FSM stays in SEND until the remaining words are read, so the packet keeps gaps but is still delivered completely.
- fmt_en deasserted mid-packet: the packet completes; no new REQ is raised.
- Reset (async, any state):
  - FSM -> IDLE; counter and len_q -> 0.
  - All outputs are 0, except fmt_chid=CH_ID and fmt_data=fifo_data.
  - A truncated packet is not resumed.

## Timing
- fmt_req is registered: it rises 1 cycle after the IDLE condition holds.
- With the grant sampled at cycle G:
  - fifo_rd_en is high in G+1..G+L.
  - fmt_valid is high in G+2..G+L+1.
  - fmt_start is at G+2; fmt_end is at G+L+1.
- fmt_req falls at G+1.
- FLUSH is cycle G+L+1. The earliest next fmt_req is G+L+3.
- Throughput: one word per cycle while granted and not empty.

## Test plan
- Length 4: preload 4 words 0xA0..0xA3, pkt_len=4, fmt_en=1, grant 3 cycles after req.
  - Expect 4 rd_en pulses, then 0xA0..0xA3 on consecutive fmt_valid cycles.
  - fmt_start on 0xA0, fmt_end on 0xA3, fmt_length=4, fmt_chid=CH_ID.
- Threshold: pkt_len=5 with occ=4.
  - Expect no fmt_req.
  - Write a 5th word; fmt_req rises 1 cycle after slack drops to 3.
- Length edges:
  - pkt_len=0 -> single word, fmt_start=fmt_end=1.
  - pkt_len=12 with FIFO_DEPTH=8 -> fmt_length=8 and 8 words out.
- Grant discipline:
  - A grant pulse in IDLE has no effect.
  - Hold off grant 20 cycles: fmt_req stays high, no reads.
  - Two back-to-back packets of 2 are separated by one FLUSH plus one IDLE cycle.
- Underflow: force fifo_empty=1 for 2 cycles mid-SEND.
  - rd_en is suppressed for those cycles; underflow_err=1 and sticky.
  - All len_q words are still delivered, with fmt_end on the last one.
- Reset mid-packet: assert rst after word 2 of 6.
  - All outputs drop to 0 immediately.
  - After release with fmt_en=0, no fmt_req is raised.
